// File: rtl/color_pkg.sv
// Shared constants and types for the colour classifier: filter select codes, colour codes,
// counter index and FSM state encoding.
package color_pkg;

  // {S2,S3} filter select codes driven onto every sensor.
  localparam logic [1:0] SEL_R = 2'b00;
  localparam logic [1:0] SEL_G = 2'b11;
  localparam logic [1:0] SEL_B = 2'b01;

  localparam logic [1:0] COL_NONE  = 2'd0;
  localparam logic [1:0] COL_RED   = 2'd1;
  localparam logic [1:0] COL_GREEN = 2'd2;
  localparam logic [1:0] COL_BLUE  = 2'd3;

  typedef enum logic [1:0] {
    FiltR = 2'd0,
    FiltG = 2'd1,
    FiltB = 2'd2
  } filt_e;

  typedef enum logic [3:0] {
    StIdle = 4'd0,
    StSetR = 4'd1,
    StCntR = 4'd2,
    StSetG = 4'd3,
    StCntG = 4'd4,
    StSetB = 4'd5,
    StCntB = 4'd6,
    StCalc = 4'd7,
    StPub  = 4'd8
  } state_e;

endpackage

// File: rtl/wave_edge_counter.sv
// Per-channel input path: 2-FF synchroniser, rising-edge detector and three saturating
// per-filter edge counters selected by filt_i.
module wave_edge_counter
  import color_pkg::*;
#(
  parameter int unsigned CNT_W = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wave_i,
  input  logic             clr_all_i,
  input  logic             clr_i,
  input  logic             cnt_en_i,
  input  filt_e            filt_i,
  output logic [CNT_W-1:0] cnt_r_o,
  output logic [CNT_W-1:0] cnt_g_o,
  output logic [CNT_W-1:0] cnt_b_o
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [1:0]       sync_q, sync_d;
  logic             prev_q, prev_d;
  logic             inc;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  always_comb begin
    sync_d = {sync_q[0], wave_i};
    prev_d = sync_q[1];
    inc    = sync_q[1] & ~prev_q;
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      cnt_d[k] = cnt_q[k];
      if (clr_all_i) begin
        cnt_d[k] = '0;
      end else if (filt_i == filt_e'(k)) begin
        if (clr_i) begin
          cnt_d[k] = '0;
        end else if (cnt_en_i && inc && (cnt_q[k] != CntMax)) begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      for (int k = 0; k < 3; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign cnt_r_o = cnt_q[0];
  assign cnt_g_o = cnt_q[1];
  assign cnt_b_o = cnt_q[2];

endmodule

// File: rtl/color_classifier.sv
// Multi-channel colour classifier: sweeps R/G/B filters, counts wave edges per filter and
// publishes a colour code per channel. Define COLOR_STABLE_EN to require two agreeing frames.
module color_classifier
  import color_pkg::*;
#(
  parameter int unsigned NCH       = 2,
  parameter int unsigned GATE_US   = 1000,
  parameter int unsigned SETTLE_US = 50,
  parameter int unsigned CNT_W     = 10,
  parameter int unsigned SHIFT_R   = 2,
  parameter int unsigned SHIFT_G   = 1,
  parameter int unsigned SHIFT_B   = 2
) (
  input  logic             clkus,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [NCH-1:0]   sensor_wave,
  output logic [2*NCH-1:0] sensor_sel,
  output logic [2*NCH-1:0] color,
  output logic             color_valid,
  output logic [7:0]       frame_cnt
);

  localparam int unsigned TmrMax = (GATE_US > SETTLE_US) ? GATE_US : SETTLE_US;
  localparam int unsigned TW     = $clog2(TmrMax + 1);
  localparam logic [TW-1:0] SettleLast = TW'(SETTLE_US - 1);
  localparam logic [TW-1:0] GateLast   = TW'(GATE_US - 1);

  state_e           state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [2*NCH-1:0] color_q, color_d;
  logic             valid_q, valid_d;
  logic [7:0]       frame_q, frame_d;
`ifdef COLOR_STABLE_EN
  logic [2*NCH-1:0] last_q, last_d;
`endif

  logic [1:0]       sel;
  logic             clr_all, clr, cnt_en;
  filt_e            filt;
  logic [CNT_W-1:0] cnt_r [NCH];
  logic [CNT_W-1:0] cnt_g [NCH];
  logic [CNT_W-1:0] cnt_b [NCH];
  logic [2*NCH-1:0] calc_vec;

  for (genvar g = 0; g < NCH; g++) begin : gen_ch
    wave_edge_counter #(
      .CNT_W(CNT_W)
    ) u_counter (
      .clk_i    (clkus),
      .rst_ni   (rst_n),
      .wave_i   (sensor_wave[g]),
      .clr_all_i(clr_all),
      .clr_i    (clr),
      .cnt_en_i (cnt_en),
      .filt_i   (filt),
      .cnt_r_o  (cnt_r[g]),
      .cnt_g_o  (cnt_g[g]),
      .cnt_b_o  (cnt_b[g])
    );
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + 1'b1;
    sel     = SEL_R;
    clr_all = 1'b0;
    clr     = 1'b0;
    cnt_en  = 1'b0;
    filt    = FiltR;
    unique case (state_q)
      StIdle: begin
        clr_all = 1'b1;
        tmr_d   = '0;
        state_d = StSetR;
      end
      StSetR: begin
        clr = 1'b1;
        if (tmr_q == SettleLast) begin
          state_d = StCntR;
          tmr_d   = '0;
        end
      end
      StCntR: begin
        cnt_en = 1'b1;
        if (tmr_q == GateLast) begin
          state_d = StSetG;
          tmr_d   = '0;
        end
      end
      StSetG: begin
        sel  = SEL_G;
        filt = FiltG;
        clr  = 1'b1;
        if (tmr_q == SettleLast) begin
          state_d = StCntG;
          tmr_d   = '0;
        end
      end
      StCntG: begin
        sel    = SEL_G;
        filt   = FiltG;
        cnt_en = 1'b1;
        if (tmr_q == GateLast) begin
          state_d = StSetB;
          tmr_d   = '0;
        end
      end
      StSetB: begin
        sel  = SEL_B;
        filt = FiltB;
        clr  = 1'b1;
        if (tmr_q == SettleLast) begin
          state_d = StCntB;
          tmr_d   = '0;
        end
      end
      StCntB: begin
        sel    = SEL_B;
        filt   = FiltB;
        cnt_en = 1'b1;
        if (tmr_q == GateLast) begin
          state_d = StCalc;
          tmr_d   = '0;
        end
      end
      StCalc: begin
        state_d = StPub;
        tmr_d   = '0;
      end
      StPub: begin
        state_d = StSetR;
        tmr_d   = '0;
      end
      default: begin
        state_d = StIdle;
        tmr_d   = '0;
      end
    endcase
    // Dropping enable abandons the frame from any state.
    if (!enable) begin
      state_d = StIdle;
      tmr_d   = '0;
    end
  end

  // Shifted count of one filter is compared against the raw counts of the other two.
  always_comb begin
    calc_vec = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      logic [CNT_W-1:0] rs, gs, bs;
      rs = cnt_r[ch] >> SHIFT_R;
      gs = cnt_g[ch] >> SHIFT_G;
      bs = cnt_b[ch] >> SHIFT_B;
      if ((rs > cnt_g[ch]) && (rs > cnt_b[ch])) begin
        calc_vec[2*ch +: 2] = COL_RED;
      end else if ((gs > cnt_r[ch]) && (gs > cnt_b[ch])) begin
        calc_vec[2*ch +: 2] = COL_GREEN;
      end else if ((bs > cnt_r[ch]) && (bs > cnt_g[ch])) begin
        calc_vec[2*ch +: 2] = COL_BLUE;
      end else begin
        calc_vec[2*ch +: 2] = COL_NONE;
      end
    end
  end

  // Results are loaded on the CALC->PUB edge so color and color_valid are both visible in PUB.
  always_comb begin
    color_d = color_q;
    valid_d = 1'b0;
    frame_d = frame_q;
`ifdef COLOR_STABLE_EN
    last_d  = last_q;
`endif
    if ((state_q == StCalc) && enable) begin
      valid_d = 1'b1;
      frame_d = frame_q + 8'd1;
`ifdef COLOR_STABLE_EN
      last_d  = calc_vec;
      for (int ch = 0; ch < NCH; ch++) begin
        if (calc_vec[2*ch +: 2] == last_q[2*ch +: 2]) begin
          color_d[2*ch +: 2] = calc_vec[2*ch +: 2];
        end
      end
`else
      color_d = calc_vec;
`endif
    end
  end

  always_ff @(posedge clkus or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tmr_q   <= '0;
      color_q <= '0;
      valid_q <= 1'b0;
      frame_q <= '0;
`ifdef COLOR_STABLE_EN
      last_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      color_q <= color_d;
      valid_q <= valid_d;
      frame_q <= frame_d;
`ifdef COLOR_STABLE_EN
      last_q  <= last_d;
`endif
    end
  end

  assign sensor_sel  = {NCH{sel}};
  assign color       = color_q;
  assign color_valid = valid_q;
  assign frame_cnt   = frame_q;

endmodule

// File: tb/tb_color_classifier.sv
// Directed bench for color_classifier: main instance (CNT_W=10) and a saturation instance
// (CNT_W=4), both with GATE_US=100 and SETTLE_US=10.
`timescale 1ns/1ps
module tb_color_classifier;
  import color_pkg::*;

  localparam int unsigned FrameLen = 3 * (10 + 100) + 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, en_s;
  logic [1:0] wave, wave_s;
  logic [3:0] sel, col, sel_s, col_s;
  logic       vld, vld_s;
  logic [7:0] fcnt, fcnt_s;

  always #500 clk = ~clk;

  color_classifier #(
    .NCH(2), .GATE_US(100), .SETTLE_US(10), .CNT_W(10),
    .SHIFT_R(2), .SHIFT_G(1), .SHIFT_B(2)
  ) u_dut (
    .clkus(clk), .rst_n(rst_n), .enable(en), .sensor_wave(wave),
    .sensor_sel(sel), .color(col), .color_valid(vld), .frame_cnt(fcnt)
  );

  color_classifier #(
    .NCH(2), .GATE_US(100), .SETTLE_US(10), .CNT_W(4),
    .SHIFT_R(2), .SHIFT_G(1), .SHIFT_B(2)
  ) u_sat (
    .clkus(clk), .rst_n(rst_n), .enable(en_s), .sensor_wave(wave_s),
    .sensor_sel(sel_s), .color(col_s), .color_valid(vld_s), .frame_cnt(fcnt_s)
  );

  // Wave period in clkus cycles per channel per filter (index R,G,B); 0 means flat.
  int unsigned per_m [2][3];
  int unsigned per_s [2][3];
  int unsigned cyc = 0;

  int checks = 0;
  int errors = 0;

  logic [1:0] last_m [2], exp_m [2], last_s [2], exp_s [2];
  int unsigned fexp_m, fexp_s;

  function automatic int fidx(input logic [1:0] s);
    case (s)
      2'b11:   return 1;
      2'b01:   return 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic gen(input int unsigned p, input int unsigned c);
    return (p != 0) && ((c % p) < (p / 2));
  endfunction

  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int ch = 0; ch < 2; ch++) begin
      wave[ch]   = gen(per_m[ch][fidx(sel[2*ch +: 2])], cyc);
      wave_s[ch] = gen(per_s[ch][fidx(sel_s[2*ch +: 2])], cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] next_col(input logic [1:0] calc, input logic [1:0] last,
                                          input logic [1:0] cur);
`ifdef COLOR_STABLE_EN
    return (calc == last) ? calc : cur;
`else
    return calc;
`endif
  endfunction

  task automatic wait_valid(input bit which, output int n);
    bit found;
    found = 1'b0;
    n = 0;
    while (!found && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
      found = which ? vld_s : vld;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout got none expected pulse");
    end
  endtask

  task automatic wait_sel(input logic [3:0] want);
    int n;
    n = 0;
    while (sel !== want && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("wait_sel", sel, want);
  endtask

  task automatic run_frame(input logic [1:0] c0, input logic [1:0] c1);
    int n;
    wait_valid(1'b0, n);
    check_eq("frame_len", n, FrameLen);
    for (int ch = 0; ch < 2; ch++) begin
      exp_m[ch]  = next_col(ch == 0 ? c0 : c1, last_m[ch], exp_m[ch]);
      last_m[ch] = ch == 0 ? c0 : c1;
    end
    fexp_m = (fexp_m + 1) % 256;
    check_eq("col_ch0", col[1:0], exp_m[0]);
    check_eq("col_ch1", col[3:2], exp_m[1]);
    check_eq("frame_cnt", fcnt, fexp_m);
  endtask

  task automatic run_sat_frame(input logic [1:0] c0, input logic [1:0] c1);
    int n;
    wait_valid(1'b1, n);
    check_eq("sat_len", n, FrameLen);
    for (int ch = 0; ch < 2; ch++) begin
      exp_s[ch]  = next_col(ch == 0 ? c0 : c1, last_s[ch], exp_s[ch]);
      last_s[ch] = ch == 0 ? c0 : c1;
    end
    fexp_s++;
    check_eq("sat_ch0", col_s[1:0], exp_s[0]);
    check_eq("sat_ch1", col_s[3:2], exp_s[1]);
    check_eq("sat_fcnt", fcnt_s, fexp_s);
  endtask

  initial begin
    int pulses;
    rst_n = 1'b1;
    en    = 1'b0;
    en_s  = 1'b0;
    for (int ch = 0; ch < 2; ch++) begin
      per_m[ch] = '{0, 0, 0};
      per_s[ch] = '{0, 0, 0};
      last_m[ch] = COL_NONE; exp_m[ch] = COL_NONE;
      last_s[ch] = COL_NONE; exp_s[ch] = COL_NONE;
    end
    fexp_m = 0;
    fexp_s = 0;
    #10 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_sel", sel, 4'b0000);
    check_eq("rst_col", col, 4'b0000);
    check_eq("rst_vld", vld, 1'b0);
    check_eq("rst_fcnt", fcnt, 8'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ch0: 200 kHz in R -> r=20,r'=5; 20 kHz in G/B -> g=b=2 => RED.
    // ch1: 100 kHz in G -> g=10,g'=5 > r=b=0 => GREEN.
    per_m[0] = '{5, 50, 50};
    per_m[1] = '{0, 10, 0};
    en = 1'b1;
    run_frame(COL_RED, COL_GREEN);
    run_frame(COL_RED, COL_GREEN);

    // 50 kHz everywhere: r=g=b=5, r'=1, g'=2, b'=1 -> no strict winner.
    per_m[0] = '{20, 20, 20};
    per_m[1] = '{20, 20, 20};
    run_frame(COL_NONE, COL_NONE);
    run_frame(COL_NONE, COL_NONE);

    // Abort in the middle of CNT_G.
    wait_sel(4'b1111);
    repeat (40) @(posedge clk);
    #1;
    en = 1'b0;
    @(posedge clk);
    #1;
    check_eq("abort_sel", sel, 4'b0000);
    check_eq("abort_state", u_dut.state_q, StIdle);
    pulses = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (vld) pulses++;
    end
    check_eq("abort_no_vld", pulses, 0);
    check_eq("abort_col0", col[1:0], exp_m[0]);
    check_eq("abort_col1", col[3:2], exp_m[1]);
    check_eq("abort_fcnt", fcnt, fexp_m);
    en = 1'b1;
    run_frame(COL_NONE, COL_NONE);

    // Alternating RED/GREEN, then two BLUE frames.
    for (int f = 0; f < 4; f++) begin
      if (f % 2 == 0) begin
        per_m[0] = '{5, 0, 0};
        per_m[1] = '{0, 5, 0};
        run_frame(COL_RED, COL_GREEN);
      end else begin
        per_m[0] = '{0, 5, 0};
        per_m[1] = '{5, 0, 0};
        run_frame(COL_GREEN, COL_RED);
      end
    end
    per_m[0] = '{0, 0, 5};
    per_m[1] = '{0, 0, 5};
    run_frame(COL_BLUE, COL_BLUE);
    run_frame(COL_BLUE, COL_BLUE);

    // Asynchronous reset in the middle of CNT_B, between clock edges.
    wait_sel(4'b0101);
    repeat (50) @(posedge clk);
    #200;
    rst_n = 1'b0;
    #1;
    check_eq("arst_sel", sel, 4'b0000);
    check_eq("arst_col", col, 4'b0000);
    check_eq("arst_vld", vld, 1'b0);
    check_eq("arst_fcnt", fcnt, 8'd0);
    en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // CNT_W=4: b sees 250 kHz -> 25 edges saturate at 15, b'=3 > r=2, g=0 => BLUE.
    // A wrapping counter would give 9, b'=2, not > r=2.
    per_s[0] = '{50, 0, 4};
    per_s[1] = '{0, 0, 0};
    en_s = 1'b1;
    run_sat_frame(COL_BLUE, COL_NONE);
    run_sat_frame(COL_BLUE, COL_NONE);
    en_s = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
